// File: rtl/nes_button_events_pkg.sv
// nes_pkg: shared button indices, event record and scan FSM states for the NES event path.
package nes_pkg;
    localparam logic [2:0] BTN_A      = 3'd7;
    localparam logic [2:0] BTN_B      = 3'd6;
    localparam logic [2:0] BTN_SELECT = 3'd5;
    localparam logic [2:0] BTN_START  = 3'd4;
    localparam logic [2:0] BTN_UP     = 3'd3;
    localparam logic [2:0] BTN_DOWN   = 3'd2;
    localparam logic [2:0] BTN_LEFT   = 3'd1;
    localparam logic [2:0] BTN_RIGHT  = 3'd0;

    typedef struct packed {
        logic       pressed;
        logic [2:0] idx;
    } event_t;

    typedef enum logic {IDLE, SCAN} state_t;

    // Highest set bit wins so A is reported before Right.
    function automatic logic [2:0] top_bit(input logic [7:0] m);
        top_bit = BTN_RIGHT;
        for (int i = int'(BTN_RIGHT); i <= int'(BTN_A); i++)
            if (m[i]) top_bit = 3'(i);
    endfunction
endpackage

// File: rtl/nes_event_fifo.sv
// nes_event_fifo: 4-bit synchronous FIFO with valid/ready head; a push into a full FIFO
// is accepted only when the head is popped in the same cycle.
module nes_event_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       master_clock,
    input  logic       reset,
    input  logic       push,
    input  logic [3:0] push_data,
    output logic       full,
    output logic       pop,
    output logic       valid,
    input  logic       ready,
    output logic [3:0] data
);
    localparam int AW = $clog2(DEPTH);

    logic [3:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          wr_en;

    assign valid = count != '0;
    assign full  = count == (AW+1)'(DEPTH);
    assign pop   = valid & ready;
    assign wr_en = push & (~full | pop);
    assign data  = mem[rd_ptr];

    always_ff @(posedge master_clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(wr_en) - (AW+1)'(pop);
        end
    end
endmodule

// File: rtl/nes_button_events.sv
// nes_button_events: debounced NES button vector plus a FIFO of press/release events.
// Define NES_EVENT_REPEAT_EN to add auto-repeat press events for held buttons.
module nes_button_events
    import nes_pkg::*;
#(
    parameter int DEBOUNCE_SAMPLES = 2,
    parameter int FIFO_DEPTH       = 8,
    parameter int REPEAT_DELAY     = 30,
    parameter int REPEAT_PERIOD    = 6
) (
    input  logic       master_clock,
    input  logic       reset,
    input  logic [7:0] button_state,
    input  logic       update_clock,
    output logic       event_valid,
    input  logic       event_ready,
    output logic [3:0] event_data,
    output logic [7:0] buttons_held,
    output logic       overflow,
    input  logic       overflow_clear
);
    localparam logic [3:0] DB_LAST = 4'(DEBOUNCE_SAMPLES - 1);

    if (DEBOUNCE_SAMPLES < 1 || DEBOUNCE_SAMPLES > 15 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1)
    begin : g_bad_params
        $error("nes_button_events: illegal parameter value");
    end

    logic       uc_q, uc_d, sample_strobe, sample_vld, pending, proc;
    logic       push, pop, full, drop;
    logic [7:0] sample_q, pend_sample, cur;
    logic [7:0] held, held_next, held_upd, mask, mask_next, edge_mask, mask_set;
    logic [3:0] db_cnt [8];
    logic [3:0] db_cnt_upd [8];
    logic [2:0] idx;
    state_t     state, state_next;
    event_t     push_ev;

    assign sample_strobe = uc_q & ~uc_d;
    assign proc          = state == IDLE && (pending || sample_vld);
    assign cur           = pending ? pend_sample : sample_q;
    assign idx           = top_bit(mask);
    assign push          = state == SCAN;
    assign push_ev       = '{held[idx], idx};
    assign drop          = push & full & ~pop;
    assign buttons_held  = held;

    always_comb begin
        held_upd   = held;
        db_cnt_upd = db_cnt;
        edge_mask  = '0;
        for (int i = 0; i < 8; i++) begin
            if (cur[i] == held[i]) db_cnt_upd[i] = '0;
            else if (db_cnt[i] == DB_LAST) begin
                held_upd[i]   = ~held[i];
                db_cnt_upd[i] = '0;
                edge_mask[i]  = 1'b1;
            end else db_cnt_upd[i] = db_cnt[i] + 4'd1;
        end
    end

`ifdef NES_EVENT_REPEAT_EN
    localparam int RW = $clog2((REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD) + 1);
    localparam logic [RW-1:0] R_DLY = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] R_PER = RW'(REPEAT_PERIOD);

    logic [RW-1:0] rpt_cnt [8];
    logic [RW-1:0] rpt_cnt_upd [8];
    logic [7:0]    rpt_armed, rpt_armed_upd, rpt_mask;

    // Counts held samples from the press edge; first target is the delay, then the period.
    always_comb begin
        rpt_cnt_upd   = rpt_cnt;
        rpt_armed_upd = rpt_armed;
        rpt_mask      = '0;
        for (int i = 0; i < 8; i++) begin
            if (!held_upd[i] || edge_mask[i]) begin
                rpt_cnt_upd[i]   = '0;
                rpt_armed_upd[i] = 1'b0;
            end else if (rpt_cnt[i] + RW'(1) == (rpt_armed[i] ? R_PER : R_DLY)) begin
                rpt_cnt_upd[i]   = '0;
                rpt_armed_upd[i] = 1'b1;
                rpt_mask[i]      = 1'b1;
            end else rpt_cnt_upd[i] = rpt_cnt[i] + RW'(1);
        end
    end

    always_ff @(posedge master_clock) begin
        if (reset) begin
            rpt_armed <= '0;
            for (int i = 0; i < 8; i++) rpt_cnt[i] <= '0;
        end else if (proc) begin
            rpt_armed <= rpt_armed_upd;
            rpt_cnt   <= rpt_cnt_upd;
        end
    end

    assign mask_set = edge_mask | rpt_mask;
`else
    assign mask_set = edge_mask;
`endif

    always_ff @(posedge master_clock) begin
        if (reset) state <= IDLE;
        else state <= state_next;
    end

    always_comb begin
        state_next = state;
        held_next  = held;
        mask_next  = mask;
        if (state == IDLE) begin
            if (proc) begin
                held_next  = held_upd;
                mask_next  = mask_set;
                state_next = |mask_set ? SCAN : IDLE;
            end
        end else begin
            mask_next  = mask & ~(8'b1 << idx);
            state_next = |mask_next ? SCAN : IDLE;
        end
    end

    always_ff @(posedge master_clock) begin
        if (reset) begin
            uc_q        <= 1'b0;
            uc_d        <= 1'b0;
            sample_vld  <= 1'b0;
            sample_q    <= '0;
            pending     <= 1'b0;
            pend_sample <= '0;
            held        <= '0;
            mask        <= '0;
            overflow    <= 1'b0;
            for (int i = 0; i < 8; i++) db_cnt[i] <= '0;
        end else begin
            uc_q       <= update_clock;
            uc_d       <= uc_q;
            sample_vld <= sample_strobe;
            if (sample_strobe) sample_q <= ~button_state;
            // Samples arriving mid-scan wait in a one-deep slot; newest wins.
            if (sample_vld && (state == SCAN || pending)) begin
                pending     <= 1'b1;
                pend_sample <= sample_q;
            end else if (proc) pending <= 1'b0;
            held     <= held_next;
            mask     <= mask_next;
            overflow <= drop | (overflow & ~overflow_clear);
            if (proc) db_cnt <= db_cnt_upd;
        end
    end

    nes_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .master_clock (master_clock),
        .reset        (reset),
        .push         (push),
        .push_data    (push_ev),
        .full         (full),
        .pop          (pop),
        .valid        (event_valid),
        .ready        (event_ready),
        .data         (event_data)
    );
endmodule
